// File: rtl/iob_ibex_axi_txn_ctrl.sv
// Single-outstanding AXI4 transaction controller: takes one word read/write request,
// runs AR/R or AW/W/B with held valids, and returns one registered response pulse.
module iob_ibex_axi_txn_ctrl #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 1,
    parameter int unsigned ID_VAL = 0
) (
    input  logic                clk_i,
    input  logic                cke_i,
    input  logic                arst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_we_i,
    input  logic [ADDR_W-3:0]   req_addr_i,
    input  logic [DATA_W-1:0]   req_wdata_i,
    input  logic [DATA_W/8-1:0] req_wstrb_i,
    output logic                rsp_valid_o,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic                rsp_err_o,
    output logic                arvalid_o,
    input  logic                arready_i,
    output logic [ADDR_W-1:0]   araddr_o,
    output logic [ID_W-1:0]     arid_o,
    output logic [7:0]          arlen_o,
    output logic [2:0]          arsize_o,
    output logic [1:0]          arburst_o,
    output logic [2:0]          arprot_o,
    input  logic                rvalid_i,
    output logic                rready_o,
    input  logic [DATA_W-1:0]   rdata_i,
    input  logic [1:0]          rresp_i,
    input  logic [ID_W-1:0]     rid_i,
    input  logic                rlast_i,
    output logic                awvalid_o,
    input  logic                awready_i,
    output logic [ADDR_W-1:0]   awaddr_o,
    output logic [ID_W-1:0]     awid_o,
    output logic [7:0]          awlen_o,
    output logic [2:0]          awsize_o,
    output logic [1:0]          awburst_o,
    output logic [2:0]          awprot_o,
    output logic                wvalid_o,
    input  logic                wready_i,
    output logic [DATA_W-1:0]   wdata_o,
    output logic [DATA_W/8-1:0] wstrb_o,
    output logic                wlast_o,
    input  logic                bvalid_i,
    output logic                bready_o,
    input  logic [1:0]          bresp_i,
    input  logic [ID_W-1:0]     bid_i
);
    localparam int unsigned STRB_W  = DATA_W / 8;
    localparam int unsigned WADDR_W = ADDR_W - 2;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_ADDR = 3'd1;
    localparam logic [2:0] S_RD_DATA = 3'd2;
    localparam logic [2:0] S_WR_REQ  = 3'd3;
    localparam logic [2:0] S_WR_RESP = 3'd4;
    localparam logic [2:0] S_RSP     = 3'd5;

    localparam logic [ID_W-1:0] ID_C = ID_W'(ID_VAL);

    logic [2:0]         state_q, state_d;
    logic [WADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [STRB_W-1:0]  wstrb_q, wstrb_d;
    logic               aw_done_q, aw_done_d;
    logic               w_done_q, w_done_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               err_q, err_d;
    logic               req_ready_q, req_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               arvalid_q, arvalid_d;
    logic               rready_q, rready_d;
    logic               awvalid_q, awvalid_d;
    logic               wvalid_q, wvalid_d;
    logic               bready_q, bready_d;

    // Next state plus output flops decoded from the next state, so every output is a flop
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        err_d     = err_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    wstrb_d = req_wstrb_i;
                    state_d = req_we_i ? S_WR_REQ : S_RD_ADDR;
                end
            end
            S_RD_ADDR: begin
                if (arready_i) state_d = S_RD_DATA;
            end
            S_RD_DATA: begin
                if (rvalid_i) begin
                    rdata_d = rdata_i;
                    err_d   = (rresp_i != 2'b00) | (rid_i != ID_C) | ~rlast_i;
                    state_d = S_RSP;
                end
            end
            S_WR_REQ: begin
                aw_done_d = aw_done_q | (awvalid_q & awready_i);
                w_done_d  = w_done_q | (wvalid_q & wready_i);
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (bvalid_i) begin
                    rdata_d = '0;
                    err_d   = (bresp_i != 2'b00) | (bid_i != ID_C);
                    state_d = S_RSP;
                end
            end
            S_RSP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RSP);
        arvalid_d   = (state_d == S_RD_ADDR);
        rready_d    = (state_d == S_RD_DATA);
        awvalid_d   = (state_d == S_WR_REQ) & ~aw_done_d;
        wvalid_d    = (state_d == S_WR_REQ) & ~w_done_d;
        bready_d    = (state_d == S_WR_RESP);
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
        end else if (cke_i) begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

    assign arvalid_o = arvalid_q;
    assign araddr_o  = {addr_q, 2'b00};
    assign arid_o    = ID_C;
    assign arlen_o   = 8'd0;
    assign arsize_o  = 3'd2;
    assign arburst_o = 2'b01;
    assign arprot_o  = 3'd0;
    assign rready_o  = rready_q;

    assign awvalid_o = awvalid_q;
    assign awaddr_o  = {addr_q, 2'b00};
    assign awid_o    = ID_C;
    assign awlen_o   = 8'd0;
    assign awsize_o  = 3'd2;
    assign awburst_o = 2'b01;
    assign awprot_o  = 3'd0;

    assign wvalid_o = wvalid_q;
    assign wdata_o  = wdata_q;
    assign wstrb_o  = wstrb_q;
    assign wlast_o  = 1'b1;
    assign bready_o = bready_q;

endmodule
